// File: rtl/tinycpu_pkg.sv
// -----------------------------------------------------------------------------
// tinycpu_pkg
// Shared definitions for the tiny CPU register-file path.
//   REG_ADDR_W / REG_DATA_W : register address and data widths
//   wb_entry_t              : one pending register write (destination + value)
// -----------------------------------------------------------------------------
package tinycpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_if.sv
// -----------------------------------------------------------------------------
// regfile_writeback_if
// Bundles every handshake and bus signal of the write-back block.
//   master : producer / decode side (drives valids, results, check addresses)
//   slave  : regfile_writeback (drives readies, write port, pending, count)
// Signals:
//   alu_valid/alu_ready/alu_addr/alu_data   ALU result handshake
//   mem_valid/mem_ready/mem_addr/mem_data   load result handshake
//   write_address/write_data/write_enable   register_file write port
//   check_addr_0/1, pending_0/1             decode hazard query
//   count                                   queue occupancy
// -----------------------------------------------------------------------------
interface regfile_writeback_if
  import tinycpu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;

  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;

  logic [ADDR_W-1:0] write_address;
  logic [DATA_W-1:0] write_data;
  logic              write_enable;

  logic [ADDR_W-1:0] check_addr_0;
  logic [ADDR_W-1:0] check_addr_1;
  logic              pending_0;
  logic              pending_1;

  logic [CNT_W-1:0]  count;

  modport master (
    output alu_valid, alu_addr, alu_data,
    output mem_valid, mem_addr, mem_data,
    output check_addr_0, check_addr_1,
    input  alu_ready, mem_ready,
    input  write_address, write_data, write_enable,
    input  pending_0, pending_1, count
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  mem_valid, mem_addr, mem_data,
    input  check_addr_0, check_addr_1,
    output alu_ready, mem_ready,
    output write_address, write_data, write_enable,
    output pending_0, pending_1, count
  );

endinterface

// File: rtl/wb_queue.sv
// -----------------------------------------------------------------------------
// wb_queue
// Single-clock circular buffer with two ordered push ports and one pop port.
// Push port 0 is enqueued ahead of push port 1 when both fire on one edge.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_push0, i_push0_entry   first (older) push
//   i_push1, i_push1_entry   second (younger) push
//   i_pop               remove head entry this edge
//   o_head              entry at the head pointer
//   o_count             occupancy
//   o_occupied          per-slot occupied mask
//   o_entries           raw slot contents (for address compares)
// The caller guarantees no push overflows and no pop underflows.
// -----------------------------------------------------------------------------
module wb_queue
  import tinycpu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push0,
  input  wb_entry_t        i_push0_entry,
  input  logic             i_push1,
  input  wb_entry_t        i_push1_entry,
  input  logic             i_pop,
  output wb_entry_t        o_head,
  output logic [CNT_W-1:0] o_count,
  output logic [DEPTH-1:0] o_occupied,
  output wb_entry_t        o_entries [DEPTH]
);

  wb_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic [1:0]       w_n_push;
  logic [PTR_W-1:0] w_slot1;
  logic [CNT_W-1:0] w_count_next;

  assign w_n_push     = {1'b0, i_push0} + {1'b0, i_push1};
  // The second push lands one slot past the first only if the first fired.
  assign w_slot1      = r_tail + PTR_W'(i_push0);
  assign w_count_next = r_count + CNT_W'(w_n_push) - CNT_W'(i_pop);

  // Pointers wrap silently because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (i_push0) begin
        r_mem[r_tail] <= i_push0_entry;
      end
      if (i_push1) begin
        r_mem[w_slot1] <= i_push1_entry;
      end
      if (i_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      r_tail  <= r_tail + PTR_W'(w_n_push);
      r_count <= w_count_next;
    end
  end

  // A slot is live when its distance from the head is below the occupancy.
  always_comb begin
    o_occupied = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_occupied[i] = ({1'b0, PTR_W'(i) - r_head} < r_count);
    end
  end

  assign o_head    = r_mem[r_head];
  assign o_count   = r_count;
  assign o_entries = r_mem;

endmodule

// File: rtl/regfile_writeback.sv
// -----------------------------------------------------------------------------
// regfile_writeback
// Write-back arbiter and in-order queue in front of register_file's single
// write port. Accepts ALU and load results, drains one entry per cycle, and
// flags queued writes that match the two decode read addresses.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    regfile_writeback_if.slave (handshakes, write port, pending, count)
// -----------------------------------------------------------------------------
module regfile_writeback
  import tinycpu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_writeback_if.slave   bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  wb_entry_t        w_alu_entry;
  wb_entry_t        w_mem_entry;
  wb_entry_t        w_head;
  wb_entry_t        w_entries [DEPTH];
  logic [DEPTH-1:0] w_occupied;
  logic [CNT_W-1:0] w_count;
  logic [CNT_W:0]   w_free;
  logic             w_pop;
  logic             w_alu_ready;
  logic             w_mem_ready;
  logic             w_alu_push;
  logic             w_mem_push;
  logic             w_pending_0;
  logic             w_pending_1;

  assign w_alu_entry = '{addr: bus.alu_addr, data: bus.alu_data};
  assign w_mem_entry = '{addr: bus.mem_addr, data: bus.mem_data};

  // register_file never stalls, so any occupied head is retired this edge.
  assign w_pop = (w_count != '0);

  // Free slots include the slot vacated by this cycle's pop.
  assign w_free = (CNT_W+1)'(DEPTH) - {1'b0, w_count} + {{CNT_W{1'b0}}, w_pop};

  // MEM needs a second slot when ALU is also offering, since ALU goes first.
  assign w_alu_ready = rst_n && (w_free >= (CNT_W+1)'(1));
  assign w_mem_ready = rst_n &&
                       (w_free >= (bus.alu_valid ? (CNT_W+1)'(2) : (CNT_W+1)'(1)));

  assign w_alu_push = bus.alu_valid && w_alu_ready;
  assign w_mem_push = bus.mem_valid && w_mem_ready;

  wb_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_push0       (w_alu_push),
    .i_push0_entry (w_alu_entry),
    .i_push1       (w_mem_push),
    .i_push1_entry (w_mem_entry),
    .i_pop         (w_pop),
    .o_head        (w_head),
    .o_count       (w_count),
    .o_occupied    (w_occupied),
    .o_entries     (w_entries)
  );

  // Only entries already stored count; this cycle's pushes are not visible.
  always_comb begin
    w_pending_0 = 1'b0;
    w_pending_1 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_occupied[i] && (ADDR_W'(w_entries[i].addr) == bus.check_addr_0)) begin
        w_pending_0 = 1'b1;
      end
      if (w_occupied[i] && (ADDR_W'(w_entries[i].addr) == bus.check_addr_1)) begin
        w_pending_1 = 1'b1;
      end
    end
  end

  assign bus.alu_ready     = w_alu_ready;
  assign bus.mem_ready     = w_mem_ready;
  assign bus.write_enable  = w_pop;
  assign bus.write_address = ADDR_W'(w_head.addr);
  assign bus.write_data    = DATA_W'(w_head.data);
  assign bus.pending_0     = w_pending_0;
  assign bus.pending_1     = w_pending_1;
  assign bus.count         = w_count;

endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  regfile_writeback_if #(.DEPTH(DEPTH)) bus();

  regfile_writeback #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t        sb [$];
  logic [31:0] rf [32];
  int          n_checks = 0;
  int          n_err    = 0;
  int          m_count  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic set_idle();
    bus.alu_valid = 1'b0;
    bus.alu_addr  = '0;
    bus.alu_data  = '0;
    bus.mem_valid = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_data  = '0;
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic cycle(input bit av, input logic [4:0] aa, input logic [31:0] ad,
                       input bit mv, input logic [4:0] ma, input logic [31:0] md);
    int  f;
    bit  acc_a, acc_m;
    bus.alu_valid = av;
    bus.alu_addr  = aa;
    bus.alu_data  = ad;
    bus.mem_valid = mv;
    bus.mem_addr  = ma;
    bus.mem_data  = md;
    @(negedge clk);
    f     = DEPTH - m_count + ((m_count != 0) ? 1 : 0);
    acc_a = av && (f >= 1);
    acc_m = mv && (f >= (av ? 2 : 1));
    check("count", 32'(bus.count), m_count);
    check("alu_ready", 32'(bus.alu_ready), 32'(f >= 1));
    check("mem_ready", 32'(bus.mem_ready), 32'(f >= (av ? 2 : 1)));
    @(posedge clk);
    if (acc_a) sb.push_back('{addr: aa, data: ad});
    if (acc_m) sb.push_back('{addr: ma, data: md});
    m_count = m_count + int'(acc_a) + int'(acc_m) - ((m_count != 0) ? 1 : 0);
    #1;
    set_idle();
  endtask

  // Monitor: every write on the register_file port must be the oldest expected.
  initial begin
    exp_t e;
    for (int r = 0; r < 32; r++) rf[r] = '0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.write_enable === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write",
                   bus.write_address, bus.write_data);
        end else begin
          e = sb.pop_front();
          check("wr_addr", 32'(bus.write_address), 32'(e.addr));
          check("wr_data", bus.write_data, e.data);
        end
        rf[bus.write_address] = bus.write_data;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    set_idle();
    bus.check_addr_0 = '0;
    bus.check_addr_1 = '0;
    #1 rst_n = 1'b0;
    bus.alu_valid = 1'b1;
    bus.alu_addr  = 5'd3;
    bus.alu_data  = 32'h1234;
    bus.mem_valid = 1'b1;
    #1;
    check("rst_write_enable", 32'(bus.write_enable), 0);
    check("rst_count", 32'(bus.count), 0);
    check("rst_alu_ready", 32'(bus.alu_ready), 0);
    check("rst_mem_ready", 32'(bus.mem_ready), 0);
    check("rst_write_address", 32'(bus.write_address), 0);
    check("rst_write_data", bus.write_data, 0);
    check("rst_pending_0", 32'(bus.pending_0), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_alu_ready", 32'(bus.alu_ready), 1);
    set_idle();
    @(posedge clk);
    #1;
    m_count = 0;

    // Single ALU push of (3, 0xDEADBEEF)
    bus.check_addr_0 = 5'd3;
    bus.check_addr_1 = 5'd4;
    bus.alu_valid    = 1'b1;
    bus.alu_addr     = 5'd3;
    bus.alu_data     = 32'hDEADBEEF;
    #1;
    check("pending_ignores_incoming", 32'(bus.pending_0), 0);
    cycle(1, 5'd3, 32'hDEADBEEF, 0, 5'd0, 32'h0);
    check("single_write_enable", 32'(bus.write_enable), 1);
    check("single_write_address", 32'(bus.write_address), 3);
    check("single_write_data", bus.write_data, 32'hDEADBEEF);
    check("single_pending_0", 32'(bus.pending_0), 1);
    check("single_pending_1", 32'(bus.pending_1), 0);
    cycle(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    check("single_after_count", 32'(bus.count), 0);
    check("single_after_pending_0", 32'(bus.pending_0), 0);
    check("single_after_write_enable", 32'(bus.write_enable), 0);

    // Dual push to the same register: MEM lands last
    cycle(1, 5'd7, 32'h1, 1, 5'd7, 32'h2);
    repeat (3) cycle(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    check("reg7_final", rf[7], 32'h2);

    // Both producers every cycle from empty: count 0,2,3,4,4,4
    for (int k = 0; k < 6; k++) begin
      cycle(1, 5'(k), 32'h100 + k, 1, 5'(k + 16), 32'h200 + k);
    end
    // Full with only MEM offering: accepted, count stays at DEPTH
    cycle(0, 5'd0, 32'h0, 1, 5'd30, 32'hCAFE);
    check("full_mem_only_count", 32'(bus.count), 4);
    repeat (6) cycle(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    check("drained_all", 32'(sb.size()), 0);

    // Reset with three entries queued: nothing further is written
    bus.check_addr_0 = 5'd13;
    cycle(1, 5'd10, 32'hA0, 1, 5'd11, 32'hB0);
    cycle(1, 5'd12, 32'hC0, 1, 5'd13, 32'hD0);
    check("preflush_count", 32'(bus.count), 3);
    check("preflush_pending_0", 32'(bus.pending_0), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("flush_write_enable", 32'(bus.write_enable), 0);
    check("flush_count", 32'(bus.count), 0);
    check("flush_pending_0", 32'(bus.pending_0), 0);
    check("flush_alu_ready", 32'(bus.alu_ready), 0);
    sb.delete();
    m_count = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reflush_alu_ready", 32'(bus.alu_ready), 1);
    check("reflush_mem_ready", 32'(bus.mem_ready), 1);
    @(posedge clk);
    #1;
    repeat (4) cycle(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
